if_stage: RTL

Instruction-fetch stage of the RV32I pipeline. It owns the program counter and issues one-outstanding word fetches to instruction memory. It buffers responses across decode stalls and presents the IF/ID pipeline register: PC, instruction, and pre-extracted rs1/rs2/rd fields. Those fields drive the register bank read ports and the IDEX source-register tags used by the forwarding unit. Branch and jump redirects from EX flush the stage and restart fetch at the new PC.

---
 rtl/if_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding fetch, 1-entry skid buffer, IF/ID register.
// Optional IF_MISALIGN_TRAP_EN: a misaligned redirect target raises ifid_misalign instead of fetching.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [4:0]  ifid_rs1,
    output logic [4:0]  ifid_rs2,
    output logic [4:0]  ifid_rd,
    output logic        ifid_misalign
);

    localparam int unsigned XLEN = 32;

    // WAIT == one request outstanding; HOLD == skid full (never overlaps an outstanding request)
    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   req_pc;
    logic [XLEN-1:0]   skid_instr;
    logic [XLEN-1:0]   skid_pc;
    logic              drop;
    logic              halt;

    logic              outstanding;
    logic              skid_valid;
    logic              resp_fire;
    logic              resp_keep;
    logic              resp_to_skid;
    logic              resp_to_ifid;
    logic              skid_drain;
    logic              fetch_ok;
    logic              req_fire;
    logic [XLEN-1:0]   target_pc;
    logic              target_misalign;

`ifdef IF_MISALIGN_TRAP_EN
    assign target_pc       = redirect_pc;
    assign target_misalign = |redirect_pc[1:0];
`else
    assign target_pc       = redirect_pc & 32'hFFFF_FFFC;
    assign target_misalign = 1'b0;
`endif

    assign outstanding  = (state == ST_WAIT);
    assign skid_valid   = (state == ST_HOLD);
    assign resp_fire    = imem_rvalid & outstanding;
    assign resp_keep    = resp_fire & ~drop;
    assign resp_to_skid = resp_keep & stall & ifid_valid;
    assign resp_to_ifid = resp_keep & ~resp_to_skid;
    assign skid_drain   = skid_valid & ~stall;

    // A new request is safe once the previous response is retired without needing the skid
    assign fetch_ok  = skid_valid ? ~stall : (~outstanding | (resp_fire & ~resp_to_skid));
    assign imem_req  = ~reset & ~redirect & ~halt & fetch_ok;
    assign req_fire  = imem_req & imem_gnt;
    assign imem_addr = pc;

    assign ifid_rs1 = ifid_instr[19:15];
    assign ifid_rs2 = ifid_instr[24:20];
    assign ifid_rd  = ifid_instr[11:7];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RST;
            pc            <= RESET_PC;
            req_pc        <= RESET_PC;
            drop          <= 1'b0;
            halt          <= 1'b0;
            skid_instr    <= NOP_INSTR;
            skid_pc       <= '0;
            ifid_valid    <= 1'b0;
            ifid_pc       <= '0;
            ifid_instr    <= NOP_INSTR;
            ifid_misalign <= 1'b0;
        end else if (redirect) begin
            // Flush; a response still in flight must be thrown away when it lands
            pc            <= target_pc;
            drop          <= outstanding & ~imem_rvalid;
            halt          <= target_misalign;
            state         <= (outstanding & ~imem_rvalid) ? ST_WAIT : ST_FETCH;
            ifid_valid    <= target_misalign;
            ifid_instr    <= NOP_INSTR;
            ifid_misalign <= target_misalign;
            if (target_misalign) begin
                ifid_pc <= target_pc;
            end
        end else begin
            if (req_fire) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (resp_fire & drop) begin
                drop <= 1'b0;
            end

            if (skid_drain) begin
                ifid_valid    <= 1'b1;
                ifid_pc       <= skid_pc;
                ifid_instr    <= skid_instr;
                ifid_misalign <= 1'b0;
            end else if (resp_to_ifid) begin
                ifid_valid    <= 1'b1;
                ifid_pc       <= req_pc;
                ifid_instr    <= imem_rdata;
                ifid_misalign <= 1'b0;
            end else if (~stall) begin
                ifid_valid    <= 1'b0;
                ifid_instr    <= NOP_INSTR;
                ifid_misalign <= 1'b0;
            end

            if (resp_to_skid) begin
                skid_instr <= imem_rdata;
                skid_pc    <= req_pc;
            end

            if (req_fire) begin
                state <= ST_WAIT;
            end else if (resp_to_skid) begin
                state <= ST_HOLD;
            end else if (resp_fire | skid_drain | (state == ST_RST)) begin
                state <= ST_FETCH;
            end
        end
    end

endmodule
